// File: rtl/bnn_bus_master.sv
// Bus master that turns BNN accelerator commands into bus transactions.
// Only one transaction is outstanding at a time.
module bnn_bus_master #(
    parameter logic [31:0] BNN_BASE = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [9:0]  cmd_addr,
    input  logic [1:0]  cmd_lane,
    input  logic [1:0]  cmd_bs,
    input  logic [31:0] cmd_data,
    input  logic [7:0]  cmd_len,
    output logic        b_req,
    output logic        p_req,
    output logic        p_we,
    output logic [3:0]  p_be,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic        p_gnt,
    input  logic        p_rvalid,
    input  logic        p_err,
    input  logic [31:0] p_rdata,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        err,
    output logic        illegal
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [2:0] OP_INI   = 3'd0;
    localparam logic [2:0] OP_ACC   = 3'd1;
    localparam logic [2:0] OP_POOL  = 3'd2;
    localparam logic [2:0] OP_NORM  = 3'd3;
    localparam logic [2:0] OP_SETEN = 3'd4;
    localparam logic [2:0] OP_ILL   = 3'd5;
    localparam logic [2:0] OP_ACTIV = 3'd6;
    localparam logic [2:0] OP_NORM8 = 3'd7;

    // Offset inside the 8 KiB BNN window; bit 12 separates the data array from control registers.
    function automatic logic [12:0] win_offset(input logic [2:0] op, input logic [9:0] a,
                                               input logic [1:0] lane, input logic [1:0] bs);
        case (op)
            OP_ACC, OP_NORM, OP_NORM8: win_offset = {1'b0, a, 2'b00};
            OP_INI:                    win_offset = 13'h1000;
            OP_POOL:                   win_offset = 13'h1004;
            OP_ACTIV:                  win_offset = 13'h100C;
            OP_SETEN:                  win_offset = {1'b1, 3'b000, 1'b1, 2'b00, bs, lane, 2'b00};
            default:                   win_offset = 13'h0000;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] op);
        case (op)
            OP_NORM:  byte_en = 4'b1011;
            OP_NORM8: byte_en = 4'b1001;
            default:  byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic addr_steps(input logic [2:0] op);
        addr_steps = (op == OP_ACC) || (op == OP_NORM) || (op == OP_NORM8);
    endfunction

    state_t      state_q;
    logic        rdy_q;
    logic        b_req_q;
    logic        busy_q;
    logic        err_q;
    logic        illegal_q;
    logic        p_we_q;
    logic [2:0]  op_q;
    logic [9:0]  addr_q;
    logic [1:0]  lane_q;
    logic [1:0]  bs_q;
    logic [7:0]  beats_q;
    logic [3:0]  p_be_q;
    logic [31:0] p_addr_q;
    logic [31:0] p_wdata_q;
    logic [9:0]  addr_d;
    logic [31:0] p_addr_d;

    assign addr_d   = addr_steps(op_q) ? addr_q + 10'd1 : addr_q;
    assign p_addr_d = BNN_BASE | {19'd0, win_offset(op_q, addr_d, lane_q, bs_q)};

    // Ready is masked by rst so it reads 0 throughout reset and 1 right after release.
    assign cmd_ready = rdy_q & ~rst;
    assign b_req     = b_req_q;
    assign p_req     = 1'b0;
    assign p_we      = p_we_q;
    assign p_be      = p_be_q;
    assign p_addr    = p_addr_q;
    assign p_wdata   = p_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign illegal   = illegal_q;
    assign res_valid = (state_q == S_WAIT) & p_rvalid & (op_q == OP_ACTIV) & ~rst;
    assign res_data  = res_valid ? p_rdata : 32'h0000_0000;

    // Command FSM; all bus-facing request fields are held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b1;
            b_req_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            p_we_q    <= 1'b0;
            op_q      <= 3'd0;
            addr_q    <= 10'd0;
            lane_q    <= 2'd0;
            bs_q      <= 2'd0;
            beats_q   <= 8'd0;
            p_be_q    <= 4'h0;
            p_addr_q  <= 32'h0000_0000;
            p_wdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && rdy_q) begin
                        if (cmd_op == OP_ILL) begin
                            illegal_q <= 1'b1;
                        end else begin
                            op_q      <= cmd_op;
                            addr_q    <= cmd_addr;
                            lane_q    <= cmd_lane;
                            bs_q      <= cmd_bs;
                            beats_q   <= cmd_len;
                            p_we_q    <= (cmd_op == OP_INI) || (cmd_op == OP_SETEN);
                            p_be_q    <= byte_en(cmd_op);
                            p_addr_q  <= BNN_BASE | {19'd0, win_offset(cmd_op, cmd_addr, cmd_lane, cmd_bs)};
                            p_wdata_q <= cmd_data;
                            b_req_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            rdy_q     <= 1'b0;
                            state_q   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (p_gnt) begin
                        b_req_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // p_gnt is ignored here so a two-phase response cannot trigger a new request.
                    if (p_rvalid) begin
                        if (p_err) begin
                            err_q <= 1'b1;
                        end
                        if (beats_q == 8'd0) begin
                            busy_q  <= 1'b0;
                            rdy_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            beats_q  <= beats_q - 8'd1;
                            addr_q   <= addr_d;
                            p_addr_q <= p_addr_d;
                            b_req_q  <= 1'b1;
                            state_q  <= S_REQ;
                        end
                    end
                end
                default: begin
                    b_req_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_bus_master.sv
// Directed bench for bnn_bus_master: the bench plays the bus slave and keeps a
// per-cycle expectation of every output, checked on the falling clock edge.
module tb_bnn_bus_master;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [9:0]  cmd_addr = 10'd0;
    logic [1:0]  cmd_lane = 2'd0;
    logic [1:0]  cmd_bs = 2'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic        b_req, p_req, p_we;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_wdata;
    logic        p_gnt = 1'b0;
    logic        p_rvalid = 1'b0;
    logic        p_err = 1'b0;
    logic [31:0] p_rdata = 32'd0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        busy, err, illegal;

    bnn_bus_master #(.BNN_BASE(BASE)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_lane(cmd_lane), .cmd_bs(cmd_bs),
        .cmd_data(cmd_data), .cmd_len(cmd_len), .b_req(b_req), .p_req(p_req),
        .p_we(p_we), .p_be(p_be), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_err(p_err), .p_rdata(p_rdata),
        .res_valid(res_valid), .res_data(res_data), .busy(busy), .err(err),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int res_cnt = 0;
    logic [31:0] res_last = 32'd0;
    logic [31:0] gnt_log[$];

    // Expected outputs for the current cycle
    logic        m_chk = 1'b0;
    logic        m_ready = 1'b0, m_busy = 1'b0, m_breq = 1'b0, m_err = 1'b0, m_ill = 1'b0;
    logic        m_resv = 1'b0, m_we = 1'b0;
    logic [31:0] m_resd = 32'd0, m_paddr = 32'd0, m_wdata = 32'd0;
    logic [3:0]  m_be = 4'd0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, want);
        end
    endfunction

    function automatic logic [31:0] exp_addr(input int op, input int a, input int lane, input int bs, input int k);
        case (op)
            1, 3, 7: return BASE + 32'(((a + k) % 1024) * 4);
            0:       return BASE + 32'h1000;
            2:       return BASE + 32'h1004;
            6:       return BASE + 32'h100C;
            4:       return BASE + 32'h1100 + 32'(bs * 16 + lane * 4);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input int op);
        if (op == 3) return 4'b1011;
        if (op == 7) return 4'b1001;
        return 4'b1111;
    endfunction

    // Compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        if (m_chk) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("b_req", 32'(b_req), 32'(m_breq));
            chk("p_req", 32'(p_req), 32'd0);
            chk("err", 32'(err), 32'(m_err));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("res_valid", 32'(res_valid), 32'(m_resv));
            if (m_resv) chk("res_data", res_data, m_resd);
            if (m_breq) begin
                chk("p_addr", p_addr, m_paddr);
                chk("p_be", 32'(p_be), 32'(m_be));
                chk("p_we", 32'(p_we), 32'(m_we));
                chk("p_wdata", p_wdata, m_wdata);
            end
            if (res_valid) begin
                res_cnt++;
                res_last = res_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and act as the slave: gwait cycles of gnt low per beat,
    // rvwait cycles between grant and rvalid, error on beat err_beat.
    task automatic run_cmd(input int op, input int a, input int lane, input int bs,
                           input logic [31:0] data, input int len, input int gwait,
                           input int rvwait, input logic [31:0] rdata, input int err_beat,
                           input bit noise);
        gnt_log.delete();
        cmd_valid = 1'b1; cmd_op = 3'(op); cmd_addr = 10'(a); cmd_lane = 2'(lane);
        cmd_bs = 2'(bs); cmd_data = data; cmd_len = 8'(len);
        m_ready = 1'b1; m_busy = 1'b0; m_breq = 1'b0; m_resv = 1'b0;
        tick();
        cmd_valid = noise;
        if (noise) begin
            cmd_op = 3'd5; cmd_addr = ~cmd_addr; cmd_data = ~data;
        end
        m_ready = 1'b0; m_busy = 1'b1;
        m_we = (op == 0) || (op == 4); m_be = exp_be(op); m_wdata = data;
        for (int k = 0; k <= len; k++) begin
            m_breq = 1'b1;
            m_paddr = exp_addr(op, a, lane, bs, k);
            for (int g = 0; g < gwait; g++) begin
                p_gnt = 1'b0;
                tick();
            end
            p_gnt = 1'b1;
            gnt_log.push_back(p_addr);
            tick();
            p_gnt = 1'b0; m_breq = 1'b0;
            for (int w = 0; w < rvwait; w++) tick();
            p_rvalid = 1'b1; p_rdata = rdata + 32'(k); p_err = (k == err_beat);
            if (op == 6) p_gnt = 1'b1;
            m_resv = (op == 6); m_resd = rdata + 32'(k);
            tick();
            p_rvalid = 1'b0; p_err = 1'b0; p_gnt = 1'b0; m_resv = 1'b0;
            if (k == err_beat) m_err = 1'b1;
        end
        cmd_valid = 1'b0;
        m_breq = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        m_chk = 1'b1;
        m_ready = 1'b0;
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();

        // ACC burst of three beats with a slow grant; busy-time cmd_valid must be ignored
        run_cmd(1, 32'h010, 0, 0, 32'h1234_5678, 2, 3, 1, 32'h0, -1, 1'b1);
        chk("acc_grants", 32'(gnt_log.size()), 32'd3);
        chk("acc_addr0", gnt_log[0], 32'h0001_0040);
        chk("acc_addr1", gnt_log[1], 32'h0001_0044);
        chk("acc_addr2", gnt_log[2], 32'h0001_0048);

        // Address wrap, with a bus error on the first beat
        run_cmd(1, 32'h3FF, 0, 0, 32'h0, 1, 0, 0, 32'h0, 0, 1'b0);
        chk("wrap_addr0", gnt_log[0], 32'h0001_0FFC);
        chk("wrap_addr1", gnt_log[1], 32'h0001_0000);
        chk("err_sticky", 32'(err), 32'd1);

        run_cmd(0, 32'h155, 0, 0, 32'h0000_FFE0, 0, 1, 2, 32'h0, -1, 1'b0);
        chk("ini_addr", gnt_log[0], 32'h0001_1000);
        chk("ini_grants", 32'(gnt_log.size()), 32'd1);

        res_cnt = 0;
        run_cmd(6, 32'h0, 0, 0, 32'h0, 0, 0, 2, 32'hA5A5_0F0F, -1, 1'b0);
        chk("activ_pulses", 32'(res_cnt), 32'd1);
        chk("activ_data", res_last, 32'hA5A5_0F0F);

        run_cmd(4, 32'h0, 2, 3, 32'h0000_0001, 0, 0, 1, 32'h0, -1, 1'b0);
        chk("seten_addr", gnt_log[0], 32'h0001_1138);

        res_cnt = 0;
        run_cmd(3, 32'h005, 0, 0, 32'hCAFE_0000, 0, 2, 0, 32'h0, -1, 1'b0);
        run_cmd(7, 32'h3FE, 0, 0, 32'h0, 1, 0, 1, 32'h0, -1, 1'b0);
        chk("norm8_addr1", gnt_log[1], 32'h0001_0FFC);
        run_cmd(2, 32'h0AA, 0, 0, 32'h0, 1, 1, 1, 32'h0, -1, 1'b0);
        chk("pool_addr1", gnt_log[1], 32'h0001_1004);
        chk("nonactiv_res", 32'(res_cnt), 32'd0);

        // Illegal opcode: flagged, nothing issued
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 10'h001;
        tick();
        cmd_valid = 1'b0;
        m_ill = 1'b1;
        tick();
        chk("illegal_set", 32'(illegal), 32'd1);
        tick();

        // Reset while waiting for an ACC response, then a late response in IDLE
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 10'h020; cmd_len = 8'd3; cmd_data = 32'h0;
        tick();
        cmd_valid = 1'b0;
        m_ready = 1'b0; m_busy = 1'b1; m_breq = 1'b1;
        m_paddr = 32'h0001_0080; m_be = 4'hF; m_we = 1'b0; m_wdata = 32'h0;
        p_gnt = 1'b1;
        tick();
        p_gnt = 1'b0; m_breq = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        m_busy = 1'b0; m_err = 1'b0; m_ill = 1'b0;
        tick();
        rst = 1'b0; m_ready = 1'b1;
        res_cnt = 0;
        p_rvalid = 1'b1; p_err = 1'b1; p_rdata = 32'h1111_2222;
        tick();
        p_rvalid = 1'b0; p_err = 1'b0;
        tick();
        chk("late_rvalid_res", 32'(res_cnt), 32'd0);

        // Recovery after reset
        run_cmd(0, 32'h0, 0, 0, 32'h0000_0042, 0, 0, 0, 32'h0, -1, 1'b0);
        chk("recover_addr", gnt_log[0], 32'h0001_1000);

        m_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/bnn_bus_master.md
BNN_BUS_MASTER -- requirements
Module: bnn_bus_master

Interface
REQ-001 The module SHALL take parameter BNN_BASE, default 32'h0001_0000, as the byte base address of the BNN window; bits [12:0] are zero.
REQ-002 The module SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 Port clk, input, 1 bit: the single clock, rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port cmd_valid / cmd_ready, input / output, 1 bit each: command handshake; a command is accepted on a cycle where both are 1.
REQ-006 Port cmd_op, input, 3 bits: 0 INI, 1 ACC, 2 POOL, 3 NORM, 4 SETEN, 6 ACTIV, 7 NORM8; op 5 is illegal.
REQ-007 Ports cmd_addr (10 bits), cmd_lane (2 bits), cmd_bs (2 bits), cmd_data (32 bits), cmd_len (8 bits), all inputs: word address, SETEN lane, bank select, write data, and beat count minus 1.
REQ-008 Ports b_req and p_req, outputs, 1 bit each: BNN command request and plain memory request (p_req is always 0 in this block).
REQ-009 Ports p_we (1), p_be (4), p_addr (32), p_wdata (32), outputs: bus request fields.
REQ-010 Ports p_gnt, p_rvalid, p_err (1 each) and p_rdata (32), inputs: bus responses.
REQ-011 Ports res_valid (1) and res_data (32), outputs: ACTIV result, a 1-cycle pulse.
REQ-012 Ports busy (1), err (1), illegal (1), outputs: status; err and illegal are sticky.

Function
REQ-013 The FSM SHALL have states IDLE, REQ and WAIT; cmd_ready SHALL be 1 only in IDLE.
REQ-014 IDLE SHALL behave as follows: on accept, latch all cmd fields, set beat counter to cmd_len, go to REQ; op 5 sets illegal, stays IDLE, issues nothing.
REQ-015 REQ SHALL behave as follows:
- drive b_req=1 and hold every request field stable until p_gnt=1 is sampled;
- on b_req&p_gnt, go to WAIT with b_req=0 from the next cycle.
REQ-016 WAIT SHALL behave as follows:
- on p_rvalid=1, if the beat counter is 0 go to IDLE, else decrement it and go to REQ;
- p_gnt may be low for up to 3 cycles after an ACC grant, and REQ re-waits for it.
REQ-017 ACTIV is a two-phase response: the first phase is a grant with no rvalid and p_gnt then low, the second is rvalid with p_gnt high. WAIT SHALL handle this without issuing a new request until rvalid.
REQ-018 At most one transaction SHALL be outstanding; a new b_req is never raised before the previous rvalid.
REQ-019 p_addr encoding SHALL be BNN_BASE | field, where field is:
- ACC / NORM / NORM8: bit12=0, bits[11:2]=current address;
- INI / POOL / ACTIV: bit12=1, bit8=0, bits[3:2] = 00 / 01 / 11;
- SETEN: bit12=1, bit8=1, bits[5:4]=cmd_bs, bits[3:2]=cmd_lane.
REQ-020 p_be SHALL be 4'hF for ACC, 4'b1011 for NORM, 4'b1001 for NORM8, and 4'hF for all other ops.
REQ-021 p_we SHALL be 1 for INI and SETEN and 0 otherwise; p_wdata SHALL equal the latched cmd_data.
REQ-022 For ACC, NORM and NORM8 the current address SHALL start at cmd_addr and increment by 1 per beat, wrapping from 10'h3FF to 0; other ops SHALL repeat the same address.
REQ-023 For ACTIV, on each rvalid res_valid SHALL pulse 1 with res_data=p_rdata in the same cycle; for other ops res_valid SHALL be 0.
REQ-024 p_err=1 together with p_rvalid SHALL set err; the beat still completes normally.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 When cmd_valid is held with no accept, the command SHALL NOT be latched.

Reset
REQ-027 While rst=1 the module SHALL be in state IDLE with cmd_ready=0, b_req=0, p_req=0, p_we=0, res_valid=0, busy=0, err=0 and illegal=0.
REQ-028 In the first cycle after rst falls, cmd_ready SHALL be 1.
REQ-029 Reset asserted in REQ or WAIT SHALL abandon the transaction and drop b_req on the next edge; late responses arriving in IDLE SHALL be ignored.
REQ-030 p_addr, p_be and p_wdata are don't-care in reset.

Verification
REQ-031 ACC, cmd_addr=10'h010, len=2, with a slave holding gnt low 3 cycles after each grant -> 3 grants at p_addr offsets 0x040, 0x044, 0x048, p_be=F, then cmd_ready=1.
REQ-032 ACC, cmd_addr=10'h3FF, len=1 -> second beat at offset 0x000 (wrap).
REQ-033 INI with cmd_data=32'h0000_FFE0 -> one b_req, p_we=1, offset 0x1000, wdata=FFE0; done after 1 rvalid.
REQ-034 ACTIV with the slave's two-phase response and p_rdata=32'hA5A5_0F0F -> no second b_req before rvalid; res_valid=1 for one cycle with res_data=A5A5_0F0F.
REQ-035 SETEN with lane=2, bs=3 -> offset 0x1138, p_we=1.
REQ-036 Command with cmd_op=5 -> illegal=1 and no b_req.
REQ-037 rst during WAIT of ACC -> b_req=0, busy=0, err=0 next cycle; a later rvalid causes no res_valid.
